// File: rtl/cok_istekli_veri_yolu_birimi_pkg.sv
// Shared constants for the multi-outstanding load/store bus unit:
// read-size encodings and logic-level names.
package cok_istekli_veri_yolu_birimi_pkg;

  localparam logic [1:0] BOYUT_BAYT   = 2'd0;
  localparam logic [1:0] BOYUT_YARIM  = 2'd1;
  localparam logic [1:0] BOYUT_KELIME = 2'd2;
  localparam logic [1:0] BOYUT_CIFT   = 2'd3;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

endpackage

// File: rtl/vyb_fifo.sv
// Parametrised synchronous FIFO with wrap-around pointers and an occupancy count.
// Push while full and pop while empty are ignored.
module vyb_fifo
  import cok_istekli_veri_yolu_birimi_pkg::*;
#(
  parameter int unsigned GENISLIK = 8,
  parameter int unsigned DERINLIK = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                itme_i,
  input  logic                cekme_i,
  input  logic [GENISLIK-1:0] veri_i,
  output logic                dolu_o,
  output logic                bos_o,
  output logic [GENISLIK-1:0] bas_o
);

  localparam int unsigned IW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
  localparam int unsigned SW = $clog2(DERINLIK + 1);

  logic [GENISLIK-1:0] bellek_q [DERINLIK];
  logic [IW-1:0]       yaz_ptr_q, yaz_ptr_d;
  logic [IW-1:0]       oku_ptr_q, oku_ptr_d;
  logic [SW-1:0]       sayac_q, sayac_d;
  logic                it, cek;

  function automatic logic [IW-1:0] ilerle(input logic [IW-1:0] p);
    return (p == IW'(DERINLIK - 1)) ? '0 : p + 1'b1;
  endfunction

  assign dolu_o = (sayac_q == SW'(DERINLIK));
  assign bos_o  = (sayac_q == '0);
  assign it     = itme_i && !dolu_o;
  assign cek    = cekme_i && !bos_o;
  assign bas_o  = bellek_q[oku_ptr_q];

  always_comb begin
    yaz_ptr_d = yaz_ptr_q;
    oku_ptr_d = oku_ptr_q;
    sayac_d   = sayac_q;
    if (it) yaz_ptr_d = ilerle(yaz_ptr_q);
    if (cek) oku_ptr_d = ilerle(oku_ptr_q);
    if (it && !cek) sayac_d = sayac_q + 1'b1;
    else if (!it && cek) sayac_d = sayac_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i == HIGH) begin
      yaz_ptr_q <= '0;
      oku_ptr_q <= '0;
      sayac_q   <= '0;
    end else begin
      yaz_ptr_q <= yaz_ptr_d;
      oku_ptr_q <= oku_ptr_d;
      sayac_q   <= sayac_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (it) bellek_q[yaz_ptr_q] <= veri_i;
  end

endmodule

// File: rtl/cok_istekli_veri_yolu_birimi.sv
// Pipelined load/store bus unit: queues memory-stage requests, keeps several reads
// outstanding at the L1 port and returns size-formatted read data in order.
module cok_istekli_veri_yolu_birimi
  import cok_istekli_veri_yolu_birimi_pkg::*;
#(
  parameter int unsigned ADRES_BIT       = 32,
  parameter int unsigned VERI_BIT        = 32,
  parameter int unsigned KUYRUK_DERINLIK = 4,
  parameter int unsigned BEKLEYEN_MAKS   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  bib_istek_gecerli_i,
  output logic                  bib_istek_hazir_o,
  input  logic                  bib_istek_yaz_i,
  input  logic [ADRES_BIT-1:0]  bib_istek_adres_i,
  input  logic [VERI_BIT-1:0]   bib_veri_i,
  input  logic [VERI_BIT/8-1:0] bib_istek_maske_i,
  input  logic [1:0]            bib_istek_boyut_i,
  input  logic                  bib_istek_isaretli_i,
  output logic                  bellek_gecerli_o,
  output logic [VERI_BIT-1:0]   bellek_veri_o,
  input  logic                  bellek_hazir_i,
  output logic                  bos_o,
  output logic                  port_istek_gecerli_o,
  input  logic                  port_istek_hazir_i,
  output logic                  port_istek_yaz_o,
  output logic [ADRES_BIT-1:0]  port_istek_adres_o,
  output logic [VERI_BIT-1:0]   port_istek_veri_o,
  output logic [VERI_BIT/8-1:0] port_istek_maske_o,
  input  logic [VERI_BIT-1:0]   port_veri_i,
  input  logic                  port_veri_gecerli_i,
  output logic                  port_veri_hazir_o
);

  localparam int unsigned MASKE_BIT = VERI_BIT / 8;
  localparam int unsigned OFS_BIT   = $clog2(VERI_BIT / 8);
  localparam int unsigned BEK_BIT   = $clog2(BEKLEYEN_MAKS + 1);

  typedef struct packed {
    logic                 yaz;
    logic [ADRES_BIT-1:0] adres;
    logic [VERI_BIT-1:0]  veri;
    logic [MASKE_BIT-1:0] maske;
    logic [1:0]           boyut;
    logic                 isaretli;
  } istek_t;

  typedef struct packed {
    logic [OFS_BIT-1:0] ofs;
    logic [1:0]         boyut;
    logic               isaretli;
  } meta_t;

  istek_t giren, bas;
  meta_t  meta_giren, meta_bas;
  logic   kuyruk_dolu, kuyruk_bos;
  logic   meta_dolu_unused, meta_bos_unused;
  logic   itme, cekme, okuma_gonder, donus;

  logic [BEK_BIT-1:0]  bekleyen_q, bekleyen_d;
  logic [VERI_BIT-1:0] sonuc_p0;
  logic [VERI_BIT-1:0] sonuc_p1_q, sonuc_p1_d;
  logic                vld_p1_q, vld_p1_d;

  // Shift the lane down, then keep the requested field; sizes at or above the
  // bus width pass the shifted word through untouched.
  function automatic logic [VERI_BIT-1:0] bicimle(
    input logic [VERI_BIT-1:0] kelime,
    input logic [OFS_BIT-1:0]  ofs,
    input logic [1:0]          boyut,
    input logic                isaretli
  );
    logic        [VERI_BIT-1:0] kay;
    logic signed [7:0]          b8;
    logic signed [15:0]         b16;
    logic signed [31:0]         b32;
    logic signed [VERI_BIT-1:0] genis;
    kay = kelime >> {ofs, 3'b000};
    b8  = kay[7:0];
    b16 = kay[15:0];
    b32 = kay[31:0];
    genis = kay;
    if (32'(boyut) < OFS_BIT) begin
      case (boyut)
        BOYUT_BAYT:   if (isaretli) genis = VERI_BIT'(b8);  else genis = VERI_BIT'(kay[7:0]);
        BOYUT_YARIM:  if (isaretli) genis = VERI_BIT'(b16); else genis = VERI_BIT'(kay[15:0]);
        BOYUT_KELIME: if (isaretli) genis = VERI_BIT'(b32); else genis = VERI_BIT'(kay[31:0]);
        default:      genis = kay;
      endcase
    end
    return genis;
  endfunction

  assign giren = '{yaz:      bib_istek_yaz_i,
                   adres:    bib_istek_adres_i,
                   veri:     bib_veri_i,
                   maske:    bib_istek_maske_i,
                   boyut:    bib_istek_boyut_i,
                   isaretli: bib_istek_isaretli_i};

  // Stage p0: request queue and issue to the L1 port
  assign bib_istek_hazir_o = !kuyruk_dolu;
  assign itme              = bib_istek_gecerli_i && !kuyruk_dolu;

  vyb_fifo #(.GENISLIK($bits(istek_t)), .DERINLIK(KUYRUK_DERINLIK)) u_istek_kuyrugu (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .itme_i  (itme),
    .cekme_i (cekme),
    .veri_i  (giren),
    .dolu_o  (kuyruk_dolu),
    .bos_o   (kuyruk_bos),
    .bas_o   (bas)
  );

  assign port_istek_gecerli_o = !kuyruk_bos &&
                                (bas.yaz || (bekleyen_q < BEK_BIT'(BEKLEYEN_MAKS)));
  assign port_istek_yaz_o     = !kuyruk_bos && bas.yaz;
  assign port_istek_adres_o   = kuyruk_bos ? '0 : bas.adres;
  assign port_istek_veri_o    = kuyruk_bos ? '0 : bas.veri;
  assign port_istek_maske_o   = kuyruk_bos ? '0 : bas.maske;

  assign cekme        = port_istek_gecerli_o && port_istek_hazir_i;
  assign okuma_gonder = cekme && !bas.yaz;
  assign meta_giren   = '{ofs: bas.adres[OFS_BIT-1:0], boyut: bas.boyut, isaretli: bas.isaretli};

  vyb_fifo #(.GENISLIK($bits(meta_t)), .DERINLIK(BEKLEYEN_MAKS)) u_meta_kuyrugu (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .itme_i  (okuma_gonder),
    .cekme_i (donus),
    .veri_i  (meta_giren),
    .dolu_o  (meta_dolu_unused),
    .bos_o   (meta_bos_unused),
    .bas_o   (meta_bas)
  );

  assign port_veri_hazir_o = (bekleyen_q != '0) && (!vld_p1_q || bellek_hazir_i);
  assign donus             = port_veri_gecerli_i && port_veri_hazir_o;

  always_comb begin
    bekleyen_d = bekleyen_q;
    if (okuma_gonder && !donus) bekleyen_d = bekleyen_q + 1'b1;
    else if (!okuma_gonder && donus) bekleyen_d = bekleyen_q - 1'b1;
  end

  always_comb begin
    sonuc_p0 = bicimle(port_veri_i, meta_bas.ofs, meta_bas.boyut, meta_bas.isaretli);
  end

  // Stage p1: registered, formatted read result held until the consumer takes it
  always_comb begin
    vld_p1_d   = vld_p1_q;
    sonuc_p1_d = sonuc_p1_q;
    if (donus) begin
      vld_p1_d   = HIGH;
      sonuc_p1_d = sonuc_p0;
    end else if (bellek_hazir_i) begin
      vld_p1_d   = LOW;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i == HIGH) begin
      bekleyen_q <= '0;
      vld_p1_q   <= LOW;
    end else begin
      bekleyen_q <= bekleyen_d;
      vld_p1_q   <= vld_p1_d;
    end
  end

  always_ff @(posedge clk_i) begin
    sonuc_p1_q <= sonuc_p1_d;
  end

  assign bellek_gecerli_o = vld_p1_q;
  assign bellek_veri_o    = vld_p1_q ? sonuc_p1_q : '0;
  assign bos_o            = kuyruk_bos && (bekleyen_q == '0) && !vld_p1_q;

endmodule

// File: tb/tb_cok_istekli_veri_yolu_birimi.sv
// Self-checking bench: queue-based behavioural model of the bus unit, an in-order
// L1 memory model and a consumer, driven by directed cases and random traffic.
module tb_cok_istekli_veri_yolu_birimi;

  localparam int QD = 4;
  localparam int BM = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        bib_istek_gecerli_i, bib_istek_hazir_o, bib_istek_yaz_i;
  logic [31:0] bib_istek_adres_i, bib_veri_i;
  logic [3:0]  bib_istek_maske_i;
  logic [1:0]  bib_istek_boyut_i;
  logic        bib_istek_isaretli_i;
  logic        bellek_gecerli_o, bellek_hazir_i, bos_o;
  logic [31:0] bellek_veri_o;
  logic        port_istek_gecerli_o, port_istek_hazir_i, port_istek_yaz_o;
  logic [31:0] port_istek_adres_o, port_istek_veri_o, port_veri_i;
  logic [3:0]  port_istek_maske_o;
  logic        port_veri_gecerli_i, port_veri_hazir_o;

  always #5 clk = ~clk;

  cok_istekli_veri_yolu_birimi #(
    .ADRES_BIT(32), .VERI_BIT(32), .KUYRUK_DERINLIK(QD), .BEKLEYEN_MAKS(BM)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst_i),
    .bib_istek_gecerli_i  (bib_istek_gecerli_i),
    .bib_istek_hazir_o    (bib_istek_hazir_o),
    .bib_istek_yaz_i      (bib_istek_yaz_i),
    .bib_istek_adres_i    (bib_istek_adres_i),
    .bib_veri_i           (bib_veri_i),
    .bib_istek_maske_i    (bib_istek_maske_i),
    .bib_istek_boyut_i    (bib_istek_boyut_i),
    .bib_istek_isaretli_i (bib_istek_isaretli_i),
    .bellek_gecerli_o     (bellek_gecerli_o),
    .bellek_veri_o        (bellek_veri_o),
    .bellek_hazir_i       (bellek_hazir_i),
    .bos_o                (bos_o),
    .port_istek_gecerli_o (port_istek_gecerli_o),
    .port_istek_hazir_i   (port_istek_hazir_i),
    .port_istek_yaz_o     (port_istek_yaz_o),
    .port_istek_adres_o   (port_istek_adres_o),
    .port_istek_veri_o    (port_istek_veri_o),
    .port_istek_maske_o   (port_istek_maske_o),
    .port_veri_i          (port_veri_i),
    .port_veri_gecerli_i  (port_veri_gecerli_i),
    .port_veri_hazir_o    (port_veri_hazir_o)
  );

  typedef struct {
    bit        yaz;
    bit [31:0] adres;
    bit [31:0] veri;
    bit [3:0]  maske;
    bit [1:0]  boyut;
    bit        isr;
    bit [31:0] rdat;
  } req_t;

  typedef struct {
    req_t r;
    int   due;
  } ret_t;

  req_t offer_q[$];
  req_t mq[$];
  ret_t ret_q[$];
  bit        res_valid;
  bit [31:0] res_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int port_pct = 100, cons_pct = 100, delay = 1;
  bit ret_en = 1, spur_en = 0, rst_req = 1;

  int        port_cyc[$];
  bit [31:0] port_adr[$];
  bit [3:0]  port_msk[$];
  int        ret_cyc[$];
  int        res_cyc[$];
  bit [31:0] res_val[$];
  int        bib_acc = 0;
  int        gec_seen = 0;

  function automatic bit [31:0] fmt(bit [31:0] w, bit [1:0] off, bit [1:0] boyut, bit isr);
    bit [31:0] v, m;
    int n;
    v = w >> (8 * off);
    n = 8 << boyut;
    if (n >= 32) return v;
    m = (32'd1 << n) - 32'd1;
    v = v & m;
    if (isr && v[n-1]) v = v | ~m;
    return v;
  endfunction

  function automatic req_t mk(bit yaz, bit [31:0] a, bit [31:0] v, bit [3:0] m,
                              bit [1:0] b, bit s, bit [31:0] rd);
    req_t r;
    r.yaz = yaz; r.adres = a; r.veri = v; r.maske = m; r.boyut = b; r.isr = s; r.rdat = rd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive();
    rst_i = rst_req;
    if (offer_q.size() > 0) begin
      bib_istek_gecerli_i  = 1'b1;
      bib_istek_yaz_i      = offer_q[0].yaz;
      bib_istek_adres_i    = offer_q[0].adres;
      bib_veri_i           = offer_q[0].veri;
      bib_istek_maske_i    = offer_q[0].maske;
      bib_istek_boyut_i    = offer_q[0].boyut;
      bib_istek_isaretli_i = offer_q[0].isr;
    end else begin
      bib_istek_gecerli_i  = 1'b0;
      bib_istek_yaz_i      = 1'($urandom);
      bib_istek_adres_i    = $urandom;
      bib_veri_i           = $urandom;
      bib_istek_maske_i    = 4'($urandom);
      bib_istek_boyut_i    = 2'($urandom);
      bib_istek_isaretli_i = 1'($urandom);
    end
    port_istek_hazir_i = ($urandom_range(99) < port_pct);
    if (ret_en && ret_q.size() > 0 && cyc >= ret_q[0].due) begin
      port_veri_gecerli_i = 1'b1;
      port_veri_i         = ret_q[0].r.rdat;
    end else begin
      port_veri_gecerli_i = spur_en && (ret_q.size() == 0) && ($urandom_range(3) == 0);
      port_veri_i         = $urandom;
    end
    bellek_hazir_i = ($urandom_range(99) < cons_pct);
  endtask

  task automatic check_update();
    bit   exp_pgec, exp_vh, bib_hs, port_hs, ret_hs, cons_hs;
    req_t r;
    ret_t e;
    if (rst_i) begin
      mq.delete();
      ret_q.delete();
      res_valid = 1'b0;
      return;
    end
    if (port_istek_gecerli_o && port_istek_hazir_i) begin
      port_cyc.push_back(cyc);
      port_adr.push_back(port_istek_adres_o);
      port_msk.push_back(port_istek_maske_o);
    end
    if (port_veri_gecerli_i && port_veri_hazir_o) ret_cyc.push_back(cyc);
    if (bellek_gecerli_o && bellek_hazir_i) begin
      res_cyc.push_back(cyc);
      res_val.push_back(bellek_veri_o);
    end
    if (bellek_gecerli_o) gec_seen++;
    if (bib_istek_gecerli_i && bib_istek_hazir_o) bib_acc++;

    exp_pgec = (mq.size() > 0) && (mq[0].yaz || ret_q.size() < BM);
    exp_vh   = (ret_q.size() != 0) && (!res_valid || bellek_hazir_i);
    chk("bib_hazir", 32'(bib_istek_hazir_o), 32'(mq.size() < QD));
    chk("port_gecerli", 32'(port_istek_gecerli_o), 32'(exp_pgec));
    if (exp_pgec) begin
      chk("port_yaz", 32'(port_istek_yaz_o), 32'(mq[0].yaz));
      chk("port_adres", port_istek_adres_o, mq[0].adres);
      if (mq[0].yaz) begin
        chk("port_veri", port_istek_veri_o, mq[0].veri);
        chk("port_maske", 32'(port_istek_maske_o), 32'(mq[0].maske));
      end
    end
    chk("port_veri_hazir", 32'(port_veri_hazir_o), 32'(exp_vh));
    chk("bellek_gecerli", 32'(bellek_gecerli_o), 32'(res_valid));
    if (res_valid) chk("bellek_veri", bellek_veri_o, res_data);
    chk("bos", 32'(bos_o), 32'(mq.size() == 0 && ret_q.size() == 0 && !res_valid));

    bib_hs  = bib_istek_gecerli_i && (mq.size() < QD);
    port_hs = exp_pgec && port_istek_hazir_i;
    ret_hs  = port_veri_gecerli_i && exp_vh;
    cons_hs = res_valid && bellek_hazir_i;

    if (cons_hs) res_valid = 1'b0;
    if (ret_hs) begin
      e = ret_q.pop_front();
      res_data  = fmt(e.r.rdat, e.r.adres[1:0], e.r.boyut, e.r.isr);
      res_valid = 1'b1;
    end
    if (port_hs) begin
      r = mq.pop_front();
      if (!r.yaz) begin
        e.r   = r;
        e.due = cyc + delay;
        if (ret_q.size() > 0 && ret_q[$].due > e.due) e.due = ret_q[$].due;
        ret_q.push_back(e);
      end
    end
    if (bib_hs) mq.push_back(offer_q.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    check_update();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_logs();
    port_cyc.delete(); port_adr.delete(); port_msk.delete();
    ret_cyc.delete(); res_cyc.delete(); res_val.delete();
    bib_acc = 0;
    gec_seen = 0;
  endtask

  task automatic wait_res(input int n, input int budget, input string nm);
    for (int i = 0; i < budget && res_val.size() < n; i++) step();
    chk(nm, 32'(res_val.size()), 32'(n));
  endtask

  task automatic wait_idle(input int budget, input string nm);
    for (int i = 0; i < budget && !(offer_q.size() == 0 && bos_o); i++) step();
    chk(nm, 32'(bos_o), 32'd1);
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.yaz   = ($urandom_range(2) == 0);
    r.adres = $urandom;
    r.boyut = 2'($urandom);
    if (r.boyut >= 2) r.adres[1:0] = 2'b00;
    r.veri  = $urandom;
    r.maske = 4'($urandom);
    r.isr   = 1'($urandom);
    r.rdat  = $urandom;
    return r;
  endfunction

  bit [31:0] rd3 [4];

  initial begin
    rst_i = 1'b1;
    bib_istek_gecerli_i = 1'b0; bib_istek_yaz_i = 1'b0; bib_istek_adres_i = '0;
    bib_veri_i = '0; bib_istek_maske_i = '0; bib_istek_boyut_i = '0; bib_istek_isaretli_i = 1'b0;
    bellek_hazir_i = 1'b0; port_istek_hazir_i = 1'b0; port_veri_i = '0; port_veri_gecerli_i = 1'b0;

    run(3);
    rst_req = 1'b0;
    step();
    chk("rst_bib_hazir", 32'(bib_istek_hazir_o), 32'd1);
    chk("rst_bos", 32'(bos_o), 32'd1);
    chk("rst_bellek_gecerli", 32'(bellek_gecerli_o), 32'd0);
    chk("rst_bellek_veri", bellek_veri_o, 32'd0);
    chk("rst_port_gecerli", 32'(port_istek_gecerli_o), 32'd0);
    chk("rst_port_veri_hazir", 32'(port_veri_hazir_o), 32'd0);

    // signed byte read
    clear_logs();
    offer_q.push_back(mk(0, 32'h1003, 0, 0, 2'd0, 1, 32'h80FF_FF00));
    wait_res(1, 30, "t1_count");
    if (res_val.size() > 0 && ret_cyc.size() > 0) begin
      chk("t1_sbyte", res_val[0], 32'hFFFF_FF80);
      chk("t1_latency", 32'(res_cyc[0] - ret_cyc[0]), 32'd1);
    end

    // unsigned half read
    clear_logs();
    offer_q.push_back(mk(0, 32'h2002, 0, 0, 2'd1, 0, 32'hBEEF_1234));
    wait_res(1, 30, "t2_count");
    if (res_val.size() > 0) chk("t2_uhalf", res_val[0], 32'h0000_BEEF);

    // four pipelined word reads with slow data
    clear_logs();
    delay = 5;
    for (int i = 0; i < 4; i++) begin
      rd3[i] = $urandom;
      offer_q.push_back(mk(0, 32'(4 * i), 0, 0, 2'd2, 0, rd3[i]));
    end
    wait_res(4, 80, "t3_count");
    if (port_cyc.size() == 4 && res_val.size() == 4 && ret_cyc.size() > 0) begin
      chk("t3_consecutive", 32'(port_cyc[3] - port_cyc[0]), 32'd3);
      chk("t3_outstanding", 32'(port_cyc[3] < ret_cyc[0]), 32'd1);
      for (int i = 0; i < 4; i++) begin
        chk("t3_adres", port_adr[i], 32'(4 * i));
        chk("t3_order", res_val[i], rd3[i]);
      end
    end
    delay = 1;

    // outstanding limit: five reads, data withheld
    clear_logs();
    ret_en = 1'b0;
    for (int i = 0; i < 5; i++) offer_q.push_back(mk(0, 32'h300 + 32'(4 * i), 0, 0, 2'd2, 0, $urandom));
    run(15);
    chk("t4_issued", 32'(port_cyc.size()), 32'd4);
    chk("t4_gecerli_low", 32'(port_istek_gecerli_o), 32'd0);
    ret_en = 1'b1;
    wait_res(5, 60, "t4_count");
    if (port_cyc.size() >= 5 && ret_cyc.size() >= 1)
      chk("t4_next_issue", 32'(port_cyc[4] - ret_cyc[0]), 32'd1);

    // queue full with posted writes
    clear_logs();
    port_pct = 0;
    for (int i = 0; i < 5; i++) begin
      offer_q.push_back(mk(1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'(1 << (i % 4)) | 4'(i / 4 * 15), 0, 0, 0));
    end
    run(10);
    chk("t5_accepted", 32'(bib_acc), 32'd4);
    chk("t5_bib_hazir", 32'(bib_istek_hazir_o), 32'd0);
    chk("t5_bos", 32'(bos_o), 32'd0);
    port_pct = 100;
    wait_idle(40, "t5_drain_idle");
    chk("t5_drained", 32'(port_cyc.size()), 32'd5);
    chk("t5_no_result", 32'(gec_seen), 32'd0);
    if (port_cyc.size() == 5) begin
      chk("t5_adr0", port_adr[0], 32'h100); chk("t5_msk0", 32'(port_msk[0]), 32'h1);
      chk("t5_adr1", port_adr[1], 32'h104); chk("t5_msk1", 32'(port_msk[1]), 32'h2);
      chk("t5_adr2", port_adr[2], 32'h108); chk("t5_msk2", 32'(port_msk[2]), 32'h4);
      chk("t5_adr3", port_adr[3], 32'h10C); chk("t5_msk3", 32'(port_msk[3]), 32'h8);
      chk("t5_adr4", port_adr[4], 32'h110); chk("t5_msk4", 32'(port_msk[4]), 32'hF);
    end

    // consumer backpressure, then reset mid-stream
    clear_logs();
    cons_pct = 0;
    offer_q.push_back(mk(0, 32'h40, 0, 0, 2'd2, 0, 32'h1122_3344));
    offer_q.push_back(mk(0, 32'h44, 0, 0, 2'd2, 0, 32'h5566_7788));
    run(12);
    chk("t6_gecerli", 32'(bellek_gecerli_o), 32'd1);
    chk("t6_veri", bellek_veri_o, 32'h1122_3344);
    chk("t6_port_veri_hazir", 32'(port_veri_hazir_o), 32'd0);
    run(3);
    chk("t6_hold", bellek_veri_o, 32'h1122_3344);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    chk("t6_rst_gecerli", 32'(bellek_gecerli_o), 32'd0);
    chk("t6_rst_bos", 32'(bos_o), 32'd1);
    chk("t6_rst_bib_hazir", 32'(bib_istek_hazir_o), 32'd1);
    cons_pct = 100;

    // random traffic
    spur_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        port_pct = 30 + $urandom_range(70);
        cons_pct = 30 + $urandom_range(70);
        delay    = 1 + $urandom_range(5);
      end
      if (offer_q.size() < 3 && $urandom_range(99) < 60) offer_q.push_back(rand_req());
      rst_req = (c == 1500);
      step();
    end
    rst_req  = 1'b0;
    spur_en  = 1'b0;
    port_pct = 100;
    cons_pct = 100;
    wait_idle(300, "final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cok_istekli_veri_yolu_birimi.md
Name: cok_istekli_veri_yolu_birimi

Overview:
Parametrised, pipelined load/store bus unit between the memory-stage (bib) and the L1 data-cache controller port. Queues up to KUYRUK_DERINLIK requests, keeps up to BEKLEYEN_MAKS reads outstanding, and returns read data in order. Read data is size-extracted and optionally sign-extended by byte offset. Writes are posted. Replaces the single-outstanding, one-request-at-a-time bus unit.

Parameters:
ADRES_BIT, 32, address width
VERI_BIT, 32, data width; power of two, 32 or 64
KUYRUK_DERINLIK, 4, request queue entries; power of two, >=2
BEKLEYEN_MAKS, 4, maximum outstanding reads at the port; power of two, >=1

Ports:
clk_i  in  1  single clock
rst_i  in  1  synchronous, active-high reset
bib_istek_gecerli_i  in  1  request valid
bib_istek_hazir_o  out  1  request accepted when valid&&hazir
bib_istek_yaz_i  in  1  1=write, 0=read
bib_istek_adres_i  in  ADRES_BIT  byte address
bib_veri_i  in  VERI_BIT  write data, already lane-aligned
bib_istek_maske_i  in  VERI_BIT/8  write byte mask
bib_istek_boyut_i  in  2  read size: 0 byte, 1 half, 2 word, 3 dword
bib_istek_isaretli_i  in  1  read sign-extend
bellek_gecerli_o  out  1  read result valid
bellek_veri_o  out  VERI_BIT  formatted read result
bellek_hazir_i  in  1  consumer accepts result
bos_o  out  1  queue empty and no outstanding reads (fence)
port_istek_gecerli_o / port_istek_hazir_i  out/in  1  port request handshake
port_istek_yaz_o  out  1  write request
port_istek_adres_o  out  ADRES_BIT  address, forwarded unmodified
port_istek_veri_o  out  VERI_BIT  write data
port_istek_maske_o  out  VERI_BIT/8  write mask
port_veri_i  in  VERI_BIT  read data, full aligned word
port_veri_gecerli_i / port_veri_hazir_o  in/out  1  read-data handshake

Behaviour:
- Reset: queue and metadata FIFO emptied, outstanding counter 0, result register invalid. All outputs 0 except bib_istek_hazir_o=1 and bos_o=1 from the first cycle after reset. Mid-operation reset discards everything. The L1 controller shares rst_i, so no stale read data arrives after reset.
- Request queue: FIFO with wrap-around pointers and a count. bib_istek_hazir_o = !full. Full queue gives no push, even if a pop happens in the same cycle, so there is no combinational path from port_istek_hazir_i. Push and pop in the same cycle keep the count unchanged.
- Issue: port_istek_* driven directly from the queue head.
- port_istek_gecerli_o = !empty && (head.yaz || bekleyen < BEKLEYEN_MAKS). Once asserted, it and the payload stay stable until port_istek_hazir_i.
- Pop on port_istek_gecerli_o && port_istek_hazir_i. Latency: an accepted request appears on the port the next cycle at the earliest.
- Read issue: pushes {offset = adres[log2(VERI_BIT/8)-1:0], boyut, isaretli} into a metadata FIFO of depth BEKLEYEN_MAKS and increments bekleyen.
- Writes: complete for bib at queue acceptance and produce no result. They occupy port order, so reads after writes observe them.
- Read return: port_veri_hazir_o = (bekleyen != 0) && (!bellek_gecerli_o || bellek_hazir_i).
- On a return handshake: pop metadata, decrement bekleyen, then register the formatted result into bellek_veri_o and set bellek_gecerli_o the next cycle.
- A read issue and a read return in the same cycle leave bekleyen unchanged.
- bellek_gecerli_o holds with stable data until bellek_hazir_i. The result register sustains one result per cycle under continuous hazir.
- Formatting: shifted = port_veri_i >> (8*offset). Take the low 8, 16, 32 or 64 bits for boyut 0..3. Sign-extend from the field MSB if isaretli, else zero-extend.
- boyut at or above log2(VERI_BIT/8) returns the full word; isaretli is ignored for that case.
- Misaligned access is the requester's responsibility. The offset shift is applied as-is and bits above the word are zero-filled before extension.
- bos_o = queue empty && bekleyen==0 && !bellek_gecerli_o.
- port_veri_gecerli_i with bekleyen==0 is a protocol error. It is ignored; hazir_o stays 0.

Decomposition:
- Shared package/header (sabitler.vh): boyut encodings BOYUT_BAYT=0, BOYUT_YARIM=1, BOYUT_KELIME=2, BOYUT_CIFT=3; HIGH/LOW.
- One sub-module: vyb_fifo, a parametrised width/depth synchronous FIFO with push, pop, full, empty and head. Instantiate it twice: request queue and read metadata.
- The formatter stays as an always @* block inside the top module.

Test Plan:
- Single signed byte read: adres 0x1003, boyut 0, isaretli 1, port returns 0x80FF_FF00. Required: bellek_veri_o=0xFFFF_FF80, one cycle after the port handshake.
- Unsigned half read: adres 0x2002, boyut 1, isaretli 0, data 0xBEEF_1234. Required: result 0x0000_BEEF.
- Pipelining: 4 back-to-back reads (0x0, 0x4, 0x8, 0xC) with port_istek_hazir_i=1 and data delayed 5 cycles. Required: 4 port requests on consecutive cycles, bekleyen reaches 4, results returned in order.
- Outstanding limit: BEKLEYEN_MAKS=2 with 3 reads and no data returned. Required: the 3rd port_istek_gecerli_o stays 0 until the first data handshake, then issues the next cycle.
- Queue full: port_istek_hazir_i=0 with 5 writes offered. Required: 4 accepted, bib_istek_hazir_o=0 on the 5th, no bellek_gecerli_o pulses, bos_o=0. Releasing hazir drains 4 writes in order with correct masks.
- Backpressure and reset: bellek_hazir_i=0 with 2 reads returned. Required: result 1 held stable and port_veri_hazir_o=0. Then rst_i high for 1 cycle mid-stream gives bellek_gecerli_o=0, bos_o=1, bib_istek_hazir_o=1.
